// File: rtl/result_display.sv
// Result-mode display: snapshots four vote tallies, picks the winner by a serial compare,
// converts the shown tally to BCD by serial double-dabble, and scans a 4-digit 7-segment display.
module result_display #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic [7:0] cand1_votes,
    input  logic [7:0] cand2_votes,
    input  logic [7:0] cand3_votes,
    input  logic [7:0] cand4_votes,
    input  logic [3:0] select,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] winner,
    output logic       tie,
    output logic       busy,
    output logic       result_valid
);
    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, CONVERT, SHOW} state_t;

    state_t        state_reg, state_next;
    logic          mode_q_reg, armed_reg;
    logic [7:0]    snap_reg [4];
    logic [7:0]    votes_in [4];
    logic [1:0]    cmp_idx_reg;
    logic [7:0]    max_val_reg;
    logic [1:0]    max_idx_reg;
    logic          tie_run_reg;
    logic [2:0]    winner_reg;
    logic          tie_reg;
    logic [1:0]    disp_reg;
    logic [7:0]    bin_reg;
    logic [11:0]   bcd_reg;
    logic [2:0]    bit_cnt_reg;
    logic [CW-1:0] refresh_reg;
    logic [1:0]    digit_reg;

    logic          rise;
    logic          sel_any;
    logic [1:0]    sel_idx;
    logic [7:0]    cmp_cur;
    logic [7:0]    max_val_next;
    logic [1:0]    max_idx_next;
    logic          tie_run_next;
    logic [11:0]   bcd_adj;
    logic [19:0]   dd_shift;

    assign votes_in[0] = cand1_votes;
    assign votes_in[1] = cand2_votes;
    assign votes_in[2] = cand3_votes;
    assign votes_in[3] = cand4_votes;

    // armed_reg blocks a "rising edge" right after reset while mode is still held high
    assign rise    = mode & ~mode_q_reg & armed_reg;
    assign sel_any = |select;

    always_comb begin
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (select[i]) sel_idx = 2'(i);
        end
    end

    always_comb begin
        cmp_cur      = snap_reg[cmp_idx_reg];
        max_val_next = max_val_reg;
        max_idx_next = max_idx_reg;
        tie_run_next = tie_run_reg;
        if (cmp_idx_reg == 2'd0) begin
            max_val_next = cmp_cur;
            max_idx_next = 2'd0;
            tie_run_next = 1'b0;
        end else if (cmp_cur > max_val_reg) begin
            max_val_next = cmp_cur;
            max_idx_next = cmp_idx_reg;
            tie_run_next = 1'b0;
        end else if (cmp_cur == max_val_reg) begin
            tie_run_next = 1'b1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_dd_adjust
        assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                                  : bcd_reg[gi*4 +: 4];
    end
    assign dd_shift = {bcd_adj, bin_reg} << 1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rise) state_next = COMPARE;
            COMPARE: if (cmp_idx_reg == 2'd3) state_next = CONVERT;
            CONVERT: if (bit_cnt_reg == 3'd7) state_next = SHOW;
            SHOW:    if (sel_any) state_next = CONVERT;
            default: state_next = IDLE;
        endcase
        if (!mode) state_next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            mode_q_reg  <= 1'b0;
            armed_reg   <= 1'b0;
            cmp_idx_reg <= 2'd0;
            max_val_reg <= 8'd0;
            max_idx_reg <= 2'd0;
            tie_run_reg <= 1'b0;
            winner_reg  <= 3'd0;
            tie_reg     <= 1'b0;
            disp_reg    <= 2'd0;
            bin_reg     <= 8'd0;
            bcd_reg     <= 12'd0;
            bit_cnt_reg <= 3'd0;
            refresh_reg <= '0;
            digit_reg   <= 2'd0;
            for (int i = 0; i < 4; i++) snap_reg[i] <= 8'd0;
        end else begin
            state_reg  <= state_next;
            mode_q_reg <= mode;
            armed_reg  <= armed_reg | ~mode;

            if (state_reg == IDLE) begin
                refresh_reg <= '0;
                digit_reg   <= 2'd0;
            end else if (refresh_reg == CW'(REFRESH_CYCLES - 1)) begin
                refresh_reg <= '0;
                digit_reg   <= digit_reg - 2'd1;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    winner_reg  <= 3'd0;
                    tie_reg     <= 1'b0;
                    cmp_idx_reg <= 2'd0;
                    if (rise) begin
                        for (int i = 0; i < 4; i++) snap_reg[i] <= votes_in[i];
                    end
                end
                COMPARE: begin
                    max_val_reg <= max_val_next;
                    max_idx_reg <= max_idx_next;
                    tie_run_reg <= tie_run_next;
                    cmp_idx_reg <= cmp_idx_reg + 2'd1;
                    if (cmp_idx_reg == 2'd3) begin
                        winner_reg  <= {1'b0, max_idx_next} + 3'd1;
                        tie_reg     <= tie_run_next;
                        disp_reg    <= max_idx_next;
                        bin_reg     <= snap_reg[max_idx_next];
                        bcd_reg     <= 12'd0;
                        bit_cnt_reg <= 3'd0;
                    end
                end
                CONVERT: begin
                    bcd_reg     <= dd_shift[19:8];
                    bin_reg     <= dd_shift[7:0];
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                SHOW: begin
                    if (sel_any) begin
                        disp_reg    <= sel_idx;
                        bin_reg     <= snap_reg[sel_idx];
                        bcd_reg     <= 12'd0;
                        bit_cnt_reg <= 3'd0;
                    end
                end
                default: ;
            endcase

            if (!mode) begin
                winner_reg <= 3'd0;
                tie_reg    <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Digits are only lit in SHOW; COMPARE scans the enables with blank segments
    always_comb begin
        an  = 4'hF;
        seg = 7'h7F;
        if (state_reg == COMPARE || state_reg == SHOW) an = ~(4'b0001 << digit_reg);
        if (state_reg == SHOW) begin
            case (digit_reg)
                2'd3: seg = seg7({2'b00, disp_reg} + 4'd1);
                2'd2: seg = (bcd_reg[11:8] != 4'd0) ? seg7(bcd_reg[11:8]) : 7'h7F;
                2'd1: seg = (bcd_reg[11:4] != 8'd0) ? seg7(bcd_reg[7:4]) : 7'h7F;
                default: seg = seg7(bcd_reg[3:0]);
            endcase
        end
    end

    assign winner       = winner_reg;
    assign tie          = tie_reg;
    assign busy         = (state_reg == COMPARE) || (state_reg == CONVERT);
    assign result_valid = (state_reg == SHOW);

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: a cycle-level behavioural model checked every cycle,
// plus directed runs with hand-computed literal expectations.
module tb_result_display;
    localparam int R = 4;

    logic       clock = 1'b0;
    logic       reset, mode;
    logic [7:0] cand1_votes, cand2_votes, cand3_votes, cand4_votes;
    logic [3:0] select;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] winner;
    logic       tie, busy, result_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    result_display #(.REFRESH_CYCLES(R)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .cand1_votes(cand1_votes), .cand2_votes(cand2_votes),
        .cand3_votes(cand3_votes), .cand4_votes(cand4_votes),
        .select(select), .seg(seg), .an(an), .winner(winner), .tie(tie),
        .busy(busy), .result_valid(result_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_CMP = 1, P_CONV = 2, P_SHOW = 3;
    int m_phase = P_IDLE, m_left = 0, m_scan = 0, m_disp = 1;
    int m_winner = 0, m_tie = 0;
    bit m_prev = 0, m_armed = 0;
    int m_snap [4] = '{0, 0, 0, 0};
    int segtab [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

    function automatic int f_max();
        int mx = 0;
        for (int i = 0; i < 4; i++) if (m_snap[i] > mx) mx = m_snap[i];
        return mx;
    endfunction

    function automatic int f_winner();
        int mx = f_max();
        for (int i = 0; i < 4; i++) if (m_snap[i] == mx) return i + 1;
        return 0;
    endfunction

    function automatic int f_tie();
        int mx = f_max();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m_snap[i] == mx) n++;
        return (n > 1) ? 1 : 0;
    endfunction

    function automatic int f_lowest(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i + 1;
        return 0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_phase <= P_IDLE; m_winner <= 0; m_tie <= 0; m_scan <= 0;
            m_prev <= 0; m_armed <= 0;
        end else begin
            m_prev  <= mode;
            m_armed <= m_armed | !mode;
            if (!mode) begin
                m_phase <= P_IDLE; m_winner <= 0; m_tie <= 0;
            end else if (m_phase == P_IDLE) begin
                if (m_armed && !m_prev) begin
                    m_snap[0] <= cand1_votes; m_snap[1] <= cand2_votes;
                    m_snap[2] <= cand3_votes; m_snap[3] <= cand4_votes;
                    m_phase <= P_CMP; m_left <= 4; m_scan <= 0;
                end
            end else begin
                m_scan <= m_scan + 1;
                if (m_phase == P_CMP) begin
                    if (m_left == 1) begin
                        m_winner <= f_winner(); m_tie <= f_tie(); m_disp <= f_winner();
                        m_phase <= P_CONV; m_left <= 8;
                    end else m_left <= m_left - 1;
                end else if (m_phase == P_CONV) begin
                    if (m_left == 1) m_phase <= P_SHOW;
                    else m_left <= m_left - 1;
                end else if (select != 4'd0) begin
                    m_disp <= f_lowest(select); m_phase <= P_CONV; m_left <= 8;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            int d, v, exp_an, exp_seg;
            d = (4 - ((m_scan / R) % 4)) % 4;
            v = m_snap[m_disp - 1];
            exp_an = (m_phase == P_CMP || m_phase == P_SHOW) ? (~(1 << d) & 'hF) : 'hF;
            exp_seg = 'h7F;
            if (m_phase == P_SHOW) begin
                case (d)
                    3: exp_seg = segtab[m_disp];
                    2: exp_seg = (v >= 100) ? segtab[v / 100] : 'h7F;
                    1: exp_seg = (v >= 10) ? segtab[(v / 10) % 10] : 'h7F;
                    default: exp_seg = segtab[v % 10];
                endcase
            end
            chk("model_an", an, exp_an);
            chk("model_seg", seg, exp_seg);
            chk("model_winner", winner, m_winner);
            chk("model_tie", tie, m_tie);
            chk("model_busy", busy, (m_phase == P_CMP || m_phase == P_CONV) ? 1 : 0);
            chk("model_result_valid", result_valid, (m_phase == P_SHOW) ? 1 : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_votes(input int a, input int b, input int c, input int e);
        cand1_votes = 8'(a); cand2_votes = 8'(b); cand3_votes = 8'(c); cand4_votes = 8'(e);
    endtask

    task automatic wait_valid(input string nm);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (result_valid) found = 1;
        end
        chk({nm, "_wait_valid"}, found, 1);
    endtask

    task automatic expect_digit(input int d, input int code, input string nm);
        bit found = 0;
        logic [3:0] want;
        want = ~(4'b0001 << d);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (an == want) begin
                found = 1;
                chk(nm, seg, code);
            end
        end
        if (!found) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic restart(input int a, input int b, input int c, input int e);
        mode = 1'b0;
        repeat (2) @(negedge clock);
        set_votes(a, b, c, e);
        mode = 1'b1;
    endtask

    task automatic pulse_select(input logic [3:0] s);
        select = s;
        @(negedge clock);
        select = 4'd0;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; select = 4'd0;
        set_votes(0, 0, 0, 0);
        repeat (3) @(negedge clock);
        started = 1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_seg", seg, 'h7F);
        chk("reset_an", an, 'hF);
        chk("reset_winner", winner, 0);
        chk("reset_valid", result_valid, 0);
        @(negedge clock);

        // Run 1: 3,7,5,2; inputs change after the snapshot edge
        set_votes(3, 7, 5, 2);
        mode = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (i == 1) set_votes(200, 1, 1, 1);
            chk("run1_busy", busy, 1);
        end
        @(negedge clock);
        chk("run1_valid_13th", result_valid, 1);
        chk("run1_winner", winner, 2);
        chk("run1_tie", tie, 0);
        expect_digit(3, 'h24, "run1_d3");
        expect_digit(0, 'h78, "run1_d0");
        expect_digit(2, 'h7F, "run1_d2");
        expect_digit(1, 'h7F, "run1_d1");

        // Run 2: three-way tie at 9
        restart(9, 9, 4, 9);
        wait_valid("run2");
        chk("run2_winner", winner, 1);
        chk("run2_tie", tie, 1);
        expect_digit(3, 'h79, "run2_d3");
        expect_digit(0, 'h10, "run2_d0");
        expect_digit(1, 'h7F, "run2_d1");

        // Run 3: select candidate 4 showing 255, then 4'b0110 picks candidate 2
        restart(255, 0, 0, 255);
        wait_valid("run3");
        chk("run3_winner", winner, 1);
        pulse_select(4'b1000);
        for (int i = 0; i < 8; i++) begin
            chk("run3_conv_an", an, 'hF);
            @(negedge clock);
        end
        chk("run3_reshow", result_valid, 1);
        expect_digit(3, 'h19, "run3_d3");
        expect_digit(2, 'h24, "run3_d2");
        expect_digit(1, 'h12, "run3_d1");
        expect_digit(0, 'h12, "run3_d0");
        chk("run3_winner_kept", winner, 1);
        pulse_select(4'b0110);
        wait_valid("run3b");
        expect_digit(3, 'h24, "run3b_d3");
        expect_digit(0, 'h40, "run3b_d0");

        // Run 4: select during COMPARE is ignored
        restart(1, 2, 3, 40);
        repeat (2) @(negedge clock);
        pulse_select(4'b0001);
        wait_valid("run4");
        chk("run4_winner", winner, 4);
        expect_digit(3, 'h19, "run4_d3");
        expect_digit(1, 'h19, "run4_d1");
        expect_digit(0, 'h40, "run4_d0");

        // Run 5: mode drops mid-CONVERT
        restart(5, 6, 7, 8);
        repeat (8) @(negedge clock);
        chk("run5_in_convert", busy, 1);
        mode = 1'b0;
        @(negedge clock);
        chk("run5_busy", busy, 0);
        chk("run5_an", an, 'hF);
        chk("run5_winner", winner, 0);
        chk("run5_valid", result_valid, 0);

        // Run 6: reset in SHOW with mode held, then all-zero counts
        restart(10, 20, 30, 40);
        wait_valid("run6");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("run6_reset_valid", result_valid, 0);
        chk("run6_reset_winner", winner, 0);
        repeat (20) @(negedge clock);
        chk("run6_stays_idle", busy, 0);
        restart(0, 0, 0, 0);
        wait_valid("run7");
        chk("run7_winner", winner, 1);
        chk("run7_tie", tie, 1);
        expect_digit(0, 'h40, "run7_d0");
        expect_digit(3, 'h79, "run7_d3");
        expect_digit(1, 'h7F, "run7_d1");

        mode = 1'b0;
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
